// File: rtl/f1_kuz_ctr_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : f1_kuz_ctr_if / f1_kuz_ctr_core_if                              |
// | Purpose  : Bus bundles for the f1 Kuznyechik CTR front-end.                |
// |   f1_kuz_ctr_if      - user side: key/IV/data strobes in, status and       |
// |                        result out. master = user, slave = CTR front-end.   |
// |   f1_kuz_ctr_core_if - cipher core side: key/block strobes out, ready and  |
// |                        result strobes in. master = CTR front-end,          |
// |                        slave = cipher core.                                |
// | Optional : F1_CTR_LAST_EN adds din_last / din_nbytes to the user bundle.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

interface f1_kuz_ctr_if;
  logic             ready;
  logic             ks_valid;
  logic             wrap;
  logic             skey_valid_s;
  logic [31:0][7:0] skey;
  logic             iv_valid_s;
  logic [7:0][7:0]  iv;
  logic             din_valid_s;
  logic [15:0][7:0] din;
  logic             dout_valid_s;
  logic [15:0][7:0] dout;
`ifdef F1_CTR_LAST_EN
  logic             din_last;
  logic [3:0]       din_nbytes;
`endif

  modport master (
    output skey_valid_s, skey, iv_valid_s, iv, din_valid_s, din,
`ifdef F1_CTR_LAST_EN
    output din_last, din_nbytes,
`endif
    input  ready, ks_valid, wrap, dout_valid_s, dout
  );

  modport slave (
    input  skey_valid_s, skey, iv_valid_s, iv, din_valid_s, din,
`ifdef F1_CTR_LAST_EN
    input  din_last, din_nbytes,
`endif
    output ready, ks_valid, wrap, dout_valid_s, dout
  );
endinterface

interface f1_kuz_ctr_core_if;
  logic             core_ready;
  logic             core_skey_valid_s;
  logic [31:0][7:0] core_skey;
  logic             core_skey_ready_s;
  logic             core_valid_s;
  logic             core_encrypt_decrypt_n;
  logic [15:0][7:0] core_din;
  logic             core_ready_s;
  logic [15:0][7:0] core_dout;

  modport master (
    output core_skey_valid_s, core_skey, core_valid_s, core_encrypt_decrypt_n, core_din,
    input  core_ready, core_skey_ready_s, core_ready_s, core_dout
  );

  modport slave (
    input  core_skey_valid_s, core_skey, core_valid_s, core_encrypt_decrypt_n, core_din,
    output core_ready, core_skey_ready_s, core_ready_s, core_dout
  );
endinterface

`default_nettype wire

// File: rtl/f1_kuz_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : f1_kuz_ctr                                                      |
// | Purpose  : GOST R 34.13-2015 CTR-mode front-end for the f1 Kuznyechik core.|
// |            Loads the key into the core, keeps a 64-bit IV and a 64-bit     |
// |            block counter, fetches one keystream block at a time and XORs   |
// |            it with incoming 128-bit data blocks (encrypt == decrypt).      |
// | Ports    : clk      - clock                                                |
// |            reset_n  - asynchronous reset, active low                       |
// |            host     - user bundle (slave): skey/iv/din strobes in,         |
// |                       ready/ks_valid/wrap/dout_valid_s/dout out            |
// |            core     - cipher core bundle (master): key/block strobes out,  |
// |                       core_ready/core_skey_ready_s/core_ready_s/dout in    |
// | Optional : F1_CTR_LAST_EN - partial last block (din_last, din_nbytes).     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

module f1_kuz_ctr (
  input  logic              clk,
  input  logic              reset_n,
  f1_kuz_ctr_if.slave       host,
  f1_kuz_ctr_core_if.master core
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_KEY_REQ  = 3'd1,
    S_KEY_WAIT = 3'd2,
    S_WAIT_IV  = 3'd3,
    S_KS_REQ   = 3'd4,
    S_KS_WAIT  = 3'd5,
    S_READY    = 3'd6
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [255:0]   r_key;
  logic [63:0]    r_iv;
  logic [63:0]    r_ctr;
  logic [127:0]   r_ks;
  logic [127:0]   r_dout;
  logic           r_ready;
  logic           r_ks_valid;
  logic           r_wrap;
  logic           r_dout_valid;

  logic           w_skey_acc;
  logic           w_iv_acc;
  logic           w_din_req;
  logic           w_key_ld;
  logic           w_iv_ld;
  logic           w_din_acc;
  logic           w_ks_ld;
  logic           w_ctr_inc;
  logic           w_set_wrap;
  logic           w_core_skey_valid;
  logic           w_core_valid;
  logic           w_last;
  logic [127:0]   w_keep;

  // Strobe priority skey > iv > din; anything seen while ready is low is dropped.
  // r_ready is used (not the state) so the first cycle after reset release
  // ignores strobes as well.
  assign w_skey_acc = r_ready & host.skey_valid_s;
  assign w_iv_acc   = r_ready & host.iv_valid_s & ~host.skey_valid_s;
  assign w_din_req  = r_ready & host.din_valid_s & ~host.skey_valid_s & ~host.iv_valid_s;

`ifdef F1_CTR_LAST_EN
  logic [4:0] w_nbytes;

  assign w_last   = host.din_last;
  // din_nbytes == 0 encodes a full 16-byte block.
  assign w_nbytes = (host.din_nbytes == 4'd0) ? 5'd16 : {1'b0, host.din_nbytes};

  // Valid bytes are the top nbytes (byte 15 downwards); the rest are zeroed.
  always_comb begin
    w_keep = '0;
    for (int b = 0; b < 16; b++) begin
      if (!host.din_last || (5'(b) >= (5'd16 - w_nbytes))) begin
        w_keep[b*8 +: 8] = 8'hFF;
      end
    end
  end
`else
  assign w_last = 1'b0;
  assign w_keep = '1;
`endif

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and per-cycle controls
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt       = r_state;
    w_key_ld          = 1'b0;
    w_iv_ld           = 1'b0;
    w_din_acc         = 1'b0;
    w_ks_ld           = 1'b0;
    w_ctr_inc         = 1'b0;
    w_set_wrap        = 1'b0;
    w_core_skey_valid = 1'b0;
    w_core_valid      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_skey_acc) begin
          w_key_ld    = 1'b1;
          w_state_nxt = S_KEY_REQ;
        end
      end

      S_KEY_REQ: begin
        if (core.core_ready) begin
          w_core_skey_valid = 1'b1;
          w_state_nxt       = S_KEY_WAIT;
        end
      end

      S_KEY_WAIT: begin
        if (core.core_skey_ready_s) begin
          w_state_nxt = S_WAIT_IV;
        end
      end

      S_WAIT_IV: begin
        if (w_skey_acc) begin
          w_key_ld    = 1'b1;
          w_state_nxt = S_KEY_REQ;
        end else if (w_iv_acc) begin
          w_iv_ld     = 1'b1;
          w_state_nxt = S_KS_REQ;
        end
      end

      S_KS_REQ: begin
        if (core.core_ready) begin
          w_core_valid = 1'b1;
          w_ctr_inc    = 1'b1;
          w_state_nxt  = S_KS_WAIT;
        end
      end

      S_KS_WAIT: begin
        if (core.core_ready_s) begin
          w_ks_ld     = 1'b1;
          w_state_nxt = S_READY;
        end
      end

      S_READY: begin
        if (w_skey_acc) begin
          w_key_ld    = 1'b1;
          w_state_nxt = S_KEY_REQ;
        end else if (w_iv_acc) begin
          // New IV throws away the buffered keystream and refetches.
          w_iv_ld     = 1'b1;
          w_state_nxt = S_KS_REQ;
        end else if (w_din_req) begin
          w_din_acc = 1'b1;
          if (w_last) begin
            w_state_nxt = S_WAIT_IV;
          end else if (r_ctr == 64'd0) begin
            // Counter already rolled over while fetching this block: the
            // whole 2^64 space is used, so stop until a fresh IV arrives.
            w_set_wrap  = 1'b1;
            w_state_nxt = S_WAIT_IV;
          end else begin
            w_state_nxt = S_KS_REQ;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and registered status
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key        <= '0;
      r_iv         <= '0;
      r_ctr        <= '0;
      r_ks         <= '0;
      r_dout       <= '0;
      r_ready      <= 1'b0;
      r_ks_valid   <= 1'b0;
      r_wrap       <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      // Status levels track the state being entered, so they line up with
      // r_state while staying low for the first cycle out of reset.
      r_ready      <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_WAIT_IV) ||
                      (w_state_nxt == S_READY);
      r_ks_valid   <= (w_state_nxt == S_READY);
      r_dout_valid <= w_din_acc;

      if (w_key_ld) begin
        r_key <= host.skey;
      end
      if (w_iv_ld) begin
        r_iv   <= host.iv;
        r_ctr  <= '0;
        r_wrap <= 1'b0;
      end else if (w_ctr_inc) begin
        r_ctr <= r_ctr + 64'd1;
      end
      if (w_set_wrap) begin
        r_wrap <= 1'b1;
      end
      if (w_ks_ld) begin
        r_ks <= core.core_dout;
      end
      if (w_din_acc) begin
        r_dout <= (host.din ^ r_ks) & w_keep;
      end
    end
  end

  assign host.ready                  = r_ready;
  assign host.ks_valid               = r_ks_valid;
  assign host.wrap                   = r_wrap;
  assign host.dout_valid_s           = r_dout_valid;
  assign host.dout                   = r_dout;

  assign core.core_skey_valid_s      = w_core_skey_valid;
  assign core.core_skey              = r_key;
  assign core.core_valid_s           = w_core_valid;
  assign core.core_encrypt_decrypt_n = 1'b1;
  // Counter block: IV in the upper 8 bytes, counter big-endian in the lower 8.
  assign core.core_din               = {r_iv, r_ctr};

endmodule

`default_nettype wire

// File: tb/tb_f1_kuz_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_f1_kuz_ctr                                                   |
// | Purpose  : Self-checking bench for f1_kuz_ctr. Plays the cipher core       |
// |            (known-answer keystream for the GOST vectors, a keyed mixing    |
// |            function otherwise) and scores dout against a queue of          |
// |            expected results. Define F1_CTR_LAST_EN for the last-block case.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

module tb_f1_kuz_ctr;

  localparam logic [255:0] KEY_A21 =
    256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
  localparam logic [255:0] KEY_B =
    256'h0f1e2d3c4b5a69788796a5b4c3d2e1f00112233445566778899aabbccddeeff0;
  localparam logic [63:0]  IV_A = 64'h1234567890abcef0;
  localparam logic [63:0]  IV_B = 64'hcafef00d0badbeef;

  localparam logic [127:0] KAT_PT [4] = '{
    128'h1122334455667700ffeeddccbbaa9988,
    128'h00112233445566778899aabbcceeff0a,
    128'h112233445566778899aabbcceeff0a00,
    128'h2233445566778899aabbcceeff0a0011
  };
  localparam logic [127:0] KAT_CT [4] = '{
    128'hf195d8bec10ed1dbd57b5fa240bda1b8,
    128'h85eee733f6a13e5df33ce4b33c45dee4,
    128'ha5eae88be6356ed3d5e877f13564a3a5,
    128'hcb91fab1f20cbab6d1c6d15820bdba73
  };

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  f1_kuz_ctr_if      u_if ();
  f1_kuz_ctr_core_if c_if ();

  f1_kuz_ctr dut (
    .clk     (clk),
    .reset_n (reset_n),
    .host    (u_if),
    .core    (c_if)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [127:0]  sb_q [$];
  logic [255:0]  tb_key;
  logic [63:0]   tb_iv;
  logic [63:0]   tb_din_idx;
  logic [63:0]   tb_blk_ctr;
  logic [255:0]  core_key;
  int            core_lat = 2;
  bit            core_busy;
  int            n_core_blk = 0;
  int            n_viol = 0;
  int            n_dout = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Keystream the core would produce: true Kuznyechik output for the GOST
  // vector blocks (PT ^ CT), a keyed scramble of the block for everything else.
  function automatic logic [127:0] ks_model(input logic [255:0] k, input logic [127:0] blk);
    logic [127:0] r;
    r = {blk[63:0], blk[127:64]} ^ k[255:128] ^ {k[63:0], k[127:64]} ^
        128'h5a5a_3c3c_a5a5_c3c3_0f0f_f0f0_9696_6969;
    if (k == KEY_A21 && blk[127:64] == IV_A && blk[63:0] < 64'd4)
      r = KAT_PT[blk[1:0]] ^ KAT_CT[blk[1:0]];
    return r;
  endfunction

  // Cipher core model: responds core_lat cycles after a request, holds
  // core_ready low while busy, checks every counter block it is given.
  initial begin : core_model
    int           cnt;
    bit           is_key;
    logic [127:0] pend;
    cnt = 0; is_key = 0; pend = '0; core_busy = 0; core_key = '0;
    c_if.core_ready = 1'b1; c_if.core_skey_ready_s = 1'b0;
    c_if.core_ready_s = 1'b0; c_if.core_dout = '0;
    forever begin
      @(negedge clk);
      c_if.core_skey_ready_s = 1'b0;
      c_if.core_ready_s      = 1'b0;
      if (core_busy) begin
        if (cnt <= 1) begin
          core_busy = 0;
          if (is_key) c_if.core_skey_ready_s = 1'b1;
          else begin
            c_if.core_ready_s = 1'b1;
            c_if.core_dout    = pend;
          end
        end else cnt--;
      end
      c_if.core_ready = !core_busy;
      #1;
      if (c_if.core_skey_valid_s || c_if.core_valid_s) begin
        if (!c_if.core_ready || (c_if.core_skey_valid_s && c_if.core_valid_s)) n_viol++;
        core_busy = 1;
        cnt       = core_lat;
        if (c_if.core_skey_valid_s) begin
          is_key   = 1;
          core_key = c_if.core_skey;
        end else begin
          is_key = 0;
          n_core_blk++;
          check("core_din", c_if.core_din, {tb_iv, tb_blk_ctr});
          tb_blk_ctr++;
          pend = ks_model(core_key, c_if.core_din);
        end
      end
    end
  end

  // Result monitor: every dout strobe pops one expected block.
  always @(negedge clk) begin
    if (u_if.dout_valid_s) begin
      n_dout++;
      if (sb_q.size() == 0) check("dout_unexpected", 1, 0);
      else check("dout", u_if.dout, sb_q.pop_front());
    end
  end

  task automatic wait_ready(input string tag);
    int i;
    i = 0;
    while (!u_if.ready && i < 500) begin @(negedge clk); i++; end
    if (!u_if.ready) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic wait_ks(input string tag);
    int i;
    i = 0;
    while (!u_if.ks_valid && i < 500) begin @(negedge clk); i++; end
    if (!u_if.ks_valid) check({tag, "_ks_timeout"}, 0, 1);
  endtask

  task automatic send_key(input logic [255:0] k);
    wait_ready("key");
    u_if.skey = k; u_if.skey_valid_s = 1'b1; tb_key = k;
    @(negedge clk);
    u_if.skey_valid_s = 1'b0;
  endtask

  task automatic send_iv(input logic [63:0] v);
    wait_ready("iv");
    u_if.iv = v; u_if.iv_valid_s = 1'b1;
    tb_iv = v; tb_din_idx = '0; tb_blk_ctr = '0;
    @(negedge clk);
    u_if.iv_valid_s = 1'b0;
  endtask

  task automatic send_din(input logic [127:0] d, input bit last, input logic [3:0] nb);
    logic [127:0] e;
    int           nk;
    wait_ks("din");
    e = d ^ ks_model(tb_key, {tb_iv, tb_din_idx});
    if (last) begin
      nk = (nb == 4'd0) ? 16 : int'(nb);
      for (int b = 0; b < 16 - nk; b++) e[b*8 +: 8] = 8'h00;
    end
    sb_q.push_back(e);
    tb_din_idx++;
    u_if.din = d; u_if.din_valid_s = 1'b1;
`ifdef F1_CTR_LAST_EN
    u_if.din_last = last; u_if.din_nbytes = nb;
`endif
    @(negedge clk);
    u_if.din_valid_s = 1'b0;
`ifdef F1_CTR_LAST_EN
    u_if.din_last = 1'b0; u_if.din_nbytes = 4'd0;
`endif
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running, expected done");
    $fatal(1);
  end

  initial begin : main
    int snap_dout;
    int snap_blk;
    int i;
    u_if.skey_valid_s = 1'b0; u_if.skey = '0;
    u_if.iv_valid_s = 1'b0;   u_if.iv = '0;
    u_if.din_valid_s = 1'b0;  u_if.din = '0;
`ifdef F1_CTR_LAST_EN
    u_if.din_last = 1'b0; u_if.din_nbytes = 4'd0;
`endif
    tb_key = '0; tb_iv = '0; tb_din_idx = '0; tb_blk_ctr = '0;
    reset_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready",     u_if.ready, 0);
    check("rst_ks_valid",  u_if.ks_valid, 0);
    check("rst_wrap",      u_if.wrap, 0);
    check("rst_dout_vld",  u_if.dout_valid_s, 0);
    check("rst_dout",      u_if.dout, 0);
    check("rst_core_skey", c_if.core_skey_valid_s, 0);
    check("rst_core_vld",  c_if.core_valid_s, 0);
    check("rst_core_din",  c_if.core_din, 0);
    check("enc_dec_n",     c_if.core_encrypt_decrypt_n, 1);
    reset_n = 1'b1;
    #1 check("ready_first_cycle", u_if.ready, 0);
    @(negedge clk);
    check("ready_idle", u_if.ready, 1);

    // IV in IDLE is ignored
    u_if.iv = IV_B; u_if.iv_valid_s = 1'b1;
    @(negedge clk);
    u_if.iv_valid_s = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_iv_ignored", n_core_blk, 0);

    // Key load, data in WAIT_IV ignored
    send_key(KEY_A21);
    wait_ready("wait_iv");
    check("wait_iv_ks_valid", u_if.ks_valid, 0);
    check("key_to_core", core_key, KEY_A21);
    u_if.din = 128'h1; u_if.din_valid_s = 1'b1;
    @(negedge clk);
    u_if.din_valid_s = 1'b0;
    repeat (3) @(negedge clk);
    check("wait_iv_din_ignored", n_dout, 0);

    // GOST known-answer: encrypt
    send_iv(IV_A);
    for (int k = 0; k < 4; k++) send_din(KAT_PT[k], 1'b0, 4'd0);
    wait_ks("kat_enc");
    check("kat_blocks", n_core_blk, 5);

    // GOST known-answer: decrypt
    send_iv(IV_A);
    for (int k = 0; k < 4; k++) send_din(KAT_CT[k], 1'b0, 4'd0);
    repeat (3) @(negedge clk);
    check("dout_hold_pt3", u_if.dout, KAT_PT[3]);

    // Counter wrap
    wait_ks("wrap_pre");
    force dut.r_ctr = '1;
    tb_blk_ctr = '1;
    send_din(rnd128(), 1'b0, 4'd0);
    release dut.r_ctr;
    tb_din_idx = '1;
    send_din(rnd128(), 1'b0, 4'd0);
    check("wrap_set", u_if.wrap, 1);
    check("wrap_ready", u_if.ready, 1);
    check("wrap_ks_valid", u_if.ks_valid, 0);
    @(negedge clk);
    snap_dout = n_dout; snap_blk = n_core_blk;
    u_if.din = rnd128(); u_if.din_valid_s = 1'b1;
    @(negedge clk);
    u_if.din_valid_s = 1'b0;
    repeat (4) @(negedge clk);
    check("wrap_din_ignored", n_dout, snap_dout);
    check("wrap_no_fetch", n_core_blk, snap_blk);
    check("wrap_sticky", u_if.wrap, 1);
    send_iv(IV_B);
    check("wrap_cleared", u_if.wrap, 0);

    // Random data under IV_B
    for (int k = 0; k < 4; k++) send_din(rnd128(), 1'b0, 4'd0);

    // skey + iv + din together in READY: key reload only
    wait_ks("prio");
    repeat (2) @(negedge clk);
    snap_dout = n_dout; snap_blk = n_core_blk;
    u_if.skey = KEY_B; u_if.iv = IV_A; u_if.din = rnd128();
    u_if.skey_valid_s = 1'b1; u_if.iv_valid_s = 1'b1; u_if.din_valid_s = 1'b1;
    tb_key = KEY_B;
    @(negedge clk);
    u_if.skey_valid_s = 1'b0; u_if.iv_valid_s = 1'b0; u_if.din_valid_s = 1'b0;
    wait_ready("prio_reload");
    check("prio_no_dout", n_dout, snap_dout);
    check("prio_no_fetch", n_core_blk, snap_blk);
    check("prio_key", core_key, KEY_B);
    check("prio_wait_iv", u_if.ks_valid, 0);
    send_iv(IV_B);
    send_din(rnd128(), 1'b0, 4'd0);
    send_din(rnd128(), 1'b0, 4'd0);

    // Reset while the core request is in flight
    wait_ks("rst_pre");
    core_lat = 8;
    send_iv(IV_A);
    i = 0;
    while (!core_busy && i < 50) begin @(negedge clk); i++; end
    check("rst_inflight_busy", core_busy, 1);
    reset_n = 1'b0;
    #1;
    check("rst2_ready",    u_if.ready, 0);
    check("rst2_ks_valid", u_if.ks_valid, 0);
    check("rst2_dout",     u_if.dout, 0);
    check("rst2_core_din", c_if.core_din, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    snap_dout = n_dout;
    repeat (12) @(negedge clk);
    check("post_rst_ready", u_if.ready, 1);
    check("post_rst_ks_valid", u_if.ks_valid, 0);
    check("post_rst_no_dout", n_dout, snap_dout);
    check("post_rst_dout", u_if.dout, 0);
    core_lat = 2;

`ifdef F1_CTR_LAST_EN
    // Partial last block
    send_key(KEY_B);
    send_iv(IV_B);
    wait_ks("last_pre");
    snap_blk = n_core_blk;
    send_din(rnd128(), 1'b1, 4'd5);
    repeat (3) @(negedge clk);
    check("last_wait_iv", u_if.ready, 1);
    check("last_ks_valid", u_if.ks_valid, 0);
    check("last_no_fetch", n_core_blk, snap_blk);
    send_iv(IV_B);
    send_din(rnd128(), 1'b1, 4'd0);
    repeat (3) @(negedge clk);
    check("last16_ks_valid", u_if.ks_valid, 0);
`endif

    repeat (5) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    check("core_protocol", n_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/f1_kuz_ctr.md
Name: f1_kuz_ctr

Overview:
CTR-mode (GOST R 34.13-2015) front-end wrapped around the f1 Kuznyechik cipher core. Owns key load, a 64-bit IV and a 64-bit block counter, and drives the core's strobe interface to generate keystream. Buffers one keystream block and XORs it with incoming 128-bit data blocks. Encryption and decryption are the same operation.

Parameters:
none

Ports:
clk  in  1  clock
reset_n  in  1  async reset, active low
ready  out  1  level; strobes accepted this cycle (states IDLE, WAIT_IV, READY)
ks_valid  out  1  level; keystream block buffered, din_valid_s accepted (state READY)
wrap  out  1  sticky; counter wrapped, new IV required
skey_valid_s  in  1  key strobe
skey  in  [31:0][7:0]  256-bit key
iv_valid_s  in  1  IV strobe
iv  in  [7:0][7:0]  64-bit IV
din_valid_s  in  1  data strobe
din  in  [15:0][7:0]  data block
dout_valid_s  out  1  result strobe
dout  out  [15:0][7:0]  din ^ keystream, held until next result
core_ready  in  1  core ready level
core_skey_valid_s  out  1  key strobe to core
core_skey  out  [31:0][7:0]  latched key
core_skey_ready_s  in  1  core key-expansion done strobe
core_valid_s  out  1  block strobe to core
core_encrypt_decrypt_n  out  1  tied 1
core_din  out  [15:0][7:0]  counter block {iv_r, ctr_r}
core_ready_s  in  1  core result strobe
core_dout  in  [15:0][7:0]  core result

Behaviour:
- Reset (async, any state, including a core request in flight): state IDLE; ready=0 first cycle after release, then per state; ks_valid=0, wrap=0, dout_valid_s=0, dout=0, core strobes 0, iv_r=0, ctr_r=0, ks_r=0.
- Byte order: core_din bytes 15..8 = iv bytes 7..0; bytes 7..0 = ctr_r, big-endian (byte 0 = LSB).
- Core rule: core_*_valid_s pulsed one cycle, only while core_ready=1. At most one core operation outstanding. Wait for the matching response strobe before the next pulse.
- States:
  IDLE: ready=1; skey_valid_s -> latch skey -> KEY_REQ. iv and din strobes ignored.
  KEY_REQ: wait core_ready; pulse core_skey_valid_s -> KEY_WAIT.
  KEY_WAIT: core_skey_ready_s -> WAIT_IV.
  WAIT_IV: ready=1; skey_valid_s -> KEY_REQ. iv_valid_s -> iv_r<=iv, ctr_r<=0, wrap<=0 -> KS_REQ. din ignored.
  KS_REQ: wait core_ready; pulse core_valid_s; ctr_r<=ctr_r+1 (mod 2^64) -> KS_WAIT.
  KS_WAIT: core_ready_s -> ks_r<=core_dout -> READY.
  READY: ready=1, ks_valid=1. din_valid_s -> dout<=din^ks_r, dout_valid_s=1 next cycle. Then: if ctr_r==0 (wrapped), wrap<=1 -> WAIT_IV; else -> KS_REQ.
- Strobe priority in one cycle: skey > iv > din; lower-priority strobes are dropped. A new iv discards the buffered keystream.
- Strobes arriving while ready=0 are ignored.
- Latency: din strobe to dout_valid_s = 1 cycle. Keystream refill = core latency + 2 cycles.
- Counter: first keystream uses ctr=0. After 2^64 blocks, wrap=1 and no further keystream until a new IV.

Optional Feature:
- Macro F1_CTR_LAST_EN.
- When defined, adds ports din_last (in, 1) and din_nbytes (in, 4; 0 means 16).
- With din_last=1 on an accepted din strobe, dout bytes 15..(16-nbytes) = din^ks and the remaining lower bytes = 0. State then goes to WAIT_IV (keystream discarded, wrap unchanged).
- Without the macro: ports absent; all blocks are full 16 bytes.

Test Plan:
- Reset then skey = GOST 34.12 A.2.1 key, iv=64'h1234567890abcef0, four din = GOST 34.13 A.2.2 plaintext -> dout = A.2.2 CTR ciphertext. Core counter blocks {iv,0}..{iv,3}.
- Same key/iv, feed that ciphertext -> original plaintext.
- Force ctr_r=64'hFFFF_FFFF_FFFF_FFFF before KS_REQ -> after next din, wrap=1, state WAIT_IV, further din ignored. New iv clears wrap.
- In READY, skey+iv+din in the same cycle -> key reload only: no dout_valid_s, then WAIT_IV.
- reset_n low during KS_WAIT -> all outputs 0, IDLE. A stale core_ready_s after release is ignored.
- F1_CTR_LAST_EN: din_last=1, din_nbytes=5 -> dout bytes 15..11 valid, bytes 10..0 = 0, then WAIT_IV.
